// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction per two cycles, drives it to an external ALU and queues results.
// Optional statistics outputs (issued_cnt, zero_cnt) are enabled by defining ALU_ISSUE_STATS_EN.
package definitions_pkg;
    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [31:0] a;
        logic [31:0] b;
    } instruction_t;
endpackage

module alu_issue_ctrl
    import definitions_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  instruction_t in_iw,
    output logic         in_ready,
    output instruction_t alu_iw,
    input  logic [31:0]  alu_result,
    input  logic         alu_zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_result,
    output logic         out_zero,
    output logic [7:0]   out_tag
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]  issued_cnt,
    output logic [15:0]  zero_cnt
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic {IDLE, EXEC} state_t;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [7:0]  tag;
    } entry_t;

    state_t        state;
    logic [7:0]    tag_cnt;
    logic [7:0]    tag_reg;
    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    entry_t        head;

    // A push happens unconditionally in EXEC; the slot was reserved when in_ready gated the accept.
    assign push     = (state == EXEC);
    assign out_valid = (count != '0);
    assign pop      = out_valid && out_ready;
    assign in_ready = rst_n && (state == IDLE) && (count != CNT_FULL);
    assign head     = mem[rd_ptr];

    assign out_result = out_valid ? head.result : 32'd0;
    assign out_zero   = out_valid ? head.zero   : 1'b0;
    assign out_tag    = out_valid ? head.tag    : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            alu_iw  <= '0;
            tag_reg <= 8'd0;
            tag_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_ready) begin
                    alu_iw  <= in_iw;
                    tag_reg <= tag_cnt;
                    tag_cnt <= tag_cnt + 8'd1;
                    state   <= EXEC;
                end
                EXEC: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{result: alu_result, zero: alu_zero, tag: tag_reg};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_cnt <= 16'd0;
            zero_cnt   <= 16'd0;
        end else if (push) begin
            if (issued_cnt != 16'hFFFF) issued_cnt <= issued_cnt + 16'd1;
            if (alu_zero && zero_cnt != 16'hFFFF) zero_cnt <= zero_cnt + 16'd1;
        end
    end
`endif

endmodule
